// File: rtl/enemy_wave_scheduler_pkg.sv
// Shared types and constants for the enemy wave scheduler and its lane generator.
package enemy_wave_scheduler_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSpawn,
      StClear,
      StRest
   } wave_state_e;

   localparam int unsigned ScreenXMin = 144;
   localparam int unsigned ScreenXMax = 784;
   localparam int unsigned ScreenYMin = 31;
   localparam int unsigned ScreenYMax = 511;
   localparam int unsigned SpriteSize = 16;

   localparam int unsigned NumLanes = 8;
   localparam int unsigned CntWidth = 27;

   localparam logic [7:0] LfsrSeed = 8'hA5;
   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LfsrTaps = 8'hB8;

   // Never place two consecutive spawns in the same lane.
   function automatic logic [2:0] dedup_lane(input logic [2:0] raw,
                                             input logic [2:0] prev,
                                             input logic       prev_valid);
      return (prev_valid && (raw == prev)) ? raw + 3'd1 : raw;
   endfunction

endpackage

// File: rtl/enemy_wave_scheduler_lfsr.sv
// 8-bit Galois LFSR lane picker; advances only when en is high.
module wave_lane_lfsr
   import enemy_wave_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [2:0] lane
);

   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LfsrTaps : 8'h00);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LfsrSeed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lane = lfsr_q[2:0];

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Spawn sequencer for a bank of wave enemies: slot choice, lane choice, wave pacing and speed.
module enemy_wave_scheduler
   import enemy_wave_scheduler_pkg::*;
#(
   parameter int unsigned NUM_ENEMIES = 4,
   parameter int unsigned SPAWN_GAP   = 5000000,
   parameter int unsigned INTER_WAVE  = 100000000,
   parameter int unsigned BASE_SPEED  = 200000,
   parameter int unsigned SPEED_STEP  = 1000,
   parameter int unsigned MIN_SPEED   = 20000,
   parameter int unsigned LANE_LEFT   = 164,
   parameter int unsigned LANE_PITCH  = 72
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pause,
   input  logic                   game_start_on,
   input  logic                   game_over_on,
   input  logic [15:0]            score,
   input  logic [NUM_ENEMIES-1:0] enemy_active,
   output logic [NUM_ENEMIES-1:0] spawn_req,
   output logic [9:0]             spawn_x,
   output logic [23:0]            wave_speed,
   output logic [7:0]             wave_num,
   output logic                   wave_busy
);

   localparam logic [CntWidth-1:0] SpawnReload = CntWidth'(SPAWN_GAP - 1);
   localparam logic [CntWidth-1:0] RestReload  = CntWidth'(INTER_WAVE - 1);
   localparam logic [3:0]          NumSlots    = 4'(NUM_ENEMIES);
   localparam logic [39:0]         SpeedRange  = 40'(BASE_SPEED - MIN_SPEED);

   wave_state_e          state_q, state_d;
   logic [CntWidth-1:0]  gap_q, gap_d;
   logic [3:0]           spawned_q, spawned_d;
   logic [7:0]           wave_num_q, wave_num_d;
   logic [2:0]           prev_lane_q;
   logic                 prev_valid_q;
   logic [9:0]           spawn_x_q;
   logic [23:0]          wave_speed_q, wave_speed_d;

   logic [NUM_ENEMIES-1:0] free_onehot;
   logic                   free_found;
   logic                   issue;
   logic [2:0]             raw_lane, lane_sel;
   logic [9:0]             lane_x;
   logic [39:0]            speed_prod;

   wave_lane_lfsr u_lane_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (issue),
      .lane (raw_lane)
   );

   // Lowest-index free slot.
   always_comb begin
      free_onehot = '0;
      free_found  = 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         if (!enemy_active[i] && !free_found) begin
            free_onehot[i] = 1'b1;
            free_found     = 1'b1;
         end
      end
   end

   always_comb begin
      lane_sel = dedup_lane(raw_lane, prev_lane_q, prev_valid_q);
      lane_x   = 10'(LANE_LEFT + 32'(lane_sel) * LANE_PITCH);
   end

   always_comb begin
      speed_prod = 40'(score) * 40'(SPEED_STEP);
      if (speed_prod >= SpeedRange) begin
         wave_speed_d = 24'(MIN_SPEED);
      end else begin
         wave_speed_d = 24'(40'(BASE_SPEED) - speed_prod);
      end
   end

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      spawned_d  = spawned_q;
      wave_num_d = wave_num_q;
      issue      = 1'b0;

      if (game_over_on || game_start_on) begin
         state_d = StIdle;
         if (game_over_on) begin
            wave_num_d = '0;
         end
      end else if (!pause) begin
         case (state_q)
            StIdle: begin
               state_d   = StSpawn;
               gap_d     = '0;
               spawned_d = '0;
            end
            StSpawn: begin
               if (spawned_q >= NumSlots) begin
                  state_d = StClear;
               end else if (gap_q != '0) begin
                  gap_d = gap_q - 1'b1;
               end else if (free_found) begin
                  issue     = 1'b1;
                  spawned_d = spawned_q + 4'd1;
                  gap_d     = SpawnReload;
                  if (spawned_d == NumSlots) begin
                     state_d = StClear;
                  end
               end
            end
            StClear: begin
               if (enemy_active == '0) begin
                  gap_d   = RestReload;
                  state_d = StRest;
               end
            end
            StRest: begin
               if (gap_q == '0) begin
                  if (wave_num_q != 8'hFF) begin
                     wave_num_d = wave_num_q + 8'd1;
                  end
                  spawned_d = '0;
                  state_d   = StSpawn;
               end else begin
                  gap_d = gap_q - 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         gap_q        <= '0;
         spawned_q    <= '0;
         wave_num_q   <= '0;
         prev_lane_q  <= '0;
         prev_valid_q <= 1'b0;
         spawn_x_q    <= 10'(LANE_LEFT);
         wave_speed_q <= 24'(BASE_SPEED);
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         spawned_q    <= spawned_d;
         wave_num_q   <= wave_num_d;
         wave_speed_q <= wave_speed_d;
         if (issue) begin
            prev_lane_q  <= lane_sel;
            prev_valid_q <= 1'b1;
            spawn_x_q    <= lane_x;
         end
      end
   end

   // Strobe is combinational so pause or a screen change suppresses it in the same cycle.
   assign spawn_req  = issue ? free_onehot : '0;
   assign spawn_x    = issue ? lane_x : spawn_x_q;
   assign wave_speed = wave_speed_q;
   assign wave_num   = wave_num_q;
   assign wave_busy  = (state_q == StSpawn) || (state_q == StClear);

endmodule
